dvp_frame_gate: RTL

Frame-aligning front end between the camera DVP pins and `video_to_axis`. Runs on the pixel clock: after reset or enable it discards the partial frame in progress, then forwards only whole frames as registered `vid_vsync` / `vid_active_video` / `vid_data`. It also checks each line and frame against the configured geometry, with sticky error flags and a frame counter for the PS.

---
 rtl/dvp_pkg.sv | 12 +
 rtl/dvp_edge_det.sv | 31 +++
 rtl/dvp_frame_gate.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dvp_pkg.sv
// Shared types for the DVP frame gate: FSM state encoding and counter widths.
package dvp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_FRAME = 2'd2
  } dvp_state_e;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/dvp_edge_det.sv
// One-stage input register with rise/fall pulses derived from the registered copy.
module dvp_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic q_q, prev_q;

  // Resetting both stages to the same level means no edge is reported
  // until the input has actually been observed at the opposite level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      q_q    <= d_i;
      prev_q <= q_q;
    end
  end

  assign q_o    = q_q;
  assign rise_o = q_q & ~prev_q;
  assign fall_o = ~q_q & prev_q;

endmodule

// File: rtl/dvp_frame_gate.sv
// DVP front end: drops the partial frame after reset/enable, forwards whole
// frames with fixed 2-cycle latency and checks line/frame geometry.
module dvp_frame_gate
  import dvp_pkg::*;
#(
  parameter int   DATA_BITS = 8,
  parameter int   H_BITS    = 12,
  parameter int   V_BITS    = 12,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic                   vid_clk,
  input  logic                   vid_rstn,
  input  logic                   enable,
  input  logic [H_BITS-1:0]      cfg_width,
  input  logic [V_BITS-1:0]      cfg_height,
  input  logic                   in_vsync,
  input  logic                   in_href,
  input  logic [DATA_BITS-1:0]   in_data,
  output logic                   vid_vsync,
  output logic                   vid_active_video,
  output logic [DATA_BITS-1:0]   vid_data,
  output logic                   running,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   err_width,
  output logic                   err_height,
  input  logic                   err_clr
);

  logic                 vs_raw;
  logic                 vs_q, vs_rise, vs_fall;
  logic                 href_q, href_rise, href_fall;
  logic [DATA_BITS-1:0] data_q;

  assign vs_raw = ~(in_vsync ^ VSYNC_POL);

  // vs detector resets "active" so a vsync already asserted at reset release
  // is not mistaken for a frame start.
  dvp_edge_det #(.RST_VAL(1'b1)) u_vs_det (
    .clk_i  (vid_clk),
    .rst_ni (vid_rstn),
    .d_i    (vs_raw),
    .q_o    (vs_q),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  dvp_edge_det #(.RST_VAL(1'b0)) u_href_det (
    .clk_i  (vid_clk),
    .rst_ni (vid_rstn),
    .d_i    (in_href),
    .q_o    (href_q),
    .rise_o (href_rise),
    .fall_o (href_fall)
  );

  logic unused_edges;
  assign unused_edges = vs_fall ^ href_rise;

  always_ff @(posedge vid_clk or negedge vid_rstn) begin
    if (!vid_rstn) data_q <= '0;
    else           data_q <= in_data;
  end

  dvp_state_e state_q, state_d;

  always_ff @(posedge vid_clk or negedge vid_rstn) begin
    if (!vid_rstn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_SYNC;
      ST_SYNC: begin
        if (!enable)      state_d = ST_IDLE;
        else if (vs_rise) state_d = ST_FRAME;
      end
      ST_FRAME: if (vs_rise && !enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  logic in_frame, fwd, frame_start, frame_end;

  // A vs edge in FRAME both ends the current frame and, if still enabled,
  // starts the next one; the stopping edge itself is not forwarded.
  always_comb begin
    in_frame    = 1'b0;
    fwd         = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    unique case (state_q)
      ST_SYNC: begin
        fwd         = vs_rise && enable;
        frame_start = vs_rise && enable;
      end
      ST_FRAME: begin
        in_frame    = 1'b1;
        frame_end   = vs_rise;
        frame_start = vs_rise && enable;
        fwd         = !(vs_rise && !enable);
      end
      default: ;
    endcase
  end

  logic [H_BITS-1:0]      pix_q, pix_d, width_q;
  logic [V_BITS-1:0]      line_q, line_d, line_tot, height_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   err_w_q, err_w_d, err_h_q, err_h_d;
  logic                   line_end, width_bad, height_bad;

  assign line_end = href_fall && in_frame;
  // A line ending on the frame-end edge still belongs to the ending frame.
  assign line_tot   = (line_end && line_q != '1) ? line_q + V_BITS'(1) : line_q;
  assign width_bad  = line_end && (pix_q != width_q);
  assign height_bad = frame_end && (line_tot != height_q);

  always_comb begin
    pix_d = pix_q;
    if (href_fall)                         pix_d = '0;
    else if (fwd && href_q && pix_q != '1) pix_d = pix_q + H_BITS'(1);

    line_d = frame_start ? '0 : line_tot;

    frame_cnt_d = frame_end ? frame_cnt_q + FRAME_CNT_W'(1) : frame_cnt_q;

    err_w_d = width_bad  | (err_w_q & ~err_clr);
    err_h_d = height_bad | (err_h_q & ~err_clr);
  end

  always_ff @(posedge vid_clk or negedge vid_rstn) begin
    if (!vid_rstn) begin
      pix_q       <= '0;
      line_q      <= '0;
      frame_cnt_q <= '0;
      err_w_q     <= 1'b0;
      err_h_q     <= 1'b0;
      width_q     <= '0;
      height_q    <= '0;
    end else begin
      pix_q       <= pix_d;
      line_q      <= line_d;
      frame_cnt_q <= frame_cnt_d;
      err_w_q     <= err_w_d;
      err_h_q     <= err_h_d;
      if (frame_start) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
      end
    end
  end

  logic                 vsync_q, active_q;
  logic [DATA_BITS-1:0] vdata_q;

  always_ff @(posedge vid_clk or negedge vid_rstn) begin
    if (!vid_rstn) begin
      vsync_q  <= 1'b0;
      active_q <= 1'b0;
      vdata_q  <= '0;
    end else begin
      vsync_q  <= fwd & vs_q;
      active_q <= fwd & href_q;
      vdata_q  <= fwd ? data_q : '0;
    end
  end

  assign vid_vsync        = vsync_q;
  assign vid_active_video = active_q;
  assign vid_data         = vdata_q;
  assign running          = in_frame;
  assign frame_count      = frame_cnt_q;
  assign err_width        = err_w_q;
  assign err_height       = err_h_q;

endmodule
